// File: rtl/opcode_decoder_if.sv
// ALU-side command handshake between opcode_decoder (master) and the matrix ALU (slave).
interface opcode_decoder_if;
  logic       alu_valid;
  logic [1:0] alu_cmd;
  logic       alu_result;
  logic       alu_ready;
  logic       alu_done;

  modport master (
    output alu_valid, alu_cmd, alu_result,
    input  alu_ready, alu_done
  );

  modport slave (
    input  alu_valid, alu_cmd, alu_result,
    output alu_ready, alu_done
  );
endinterface

// File: rtl/opcode_decoder.sv
// Validates keypad opcode strobes, queues them in a small FIFO and issues them to the matrix ALU.
// Optional macro OPCODE_DECODER_STATS_EN enables the saturating issued-command counter on cmd_count.
module opcode_decoder #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned DONE_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic [2:0]              op_in,
  input  logic                    is_op,
  input  logic                    is_result,
  input  logic                    is_enter,
  opcode_decoder_if.master        alu,
  output logic                    busy,
  output logic                    drop_pulse,
  output logic                    illegal_pulse,
  output logic                    timeout_pulse,
  output logic [7:0]              cmd_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      mem_q [DEPTH];
  logic [AW:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic            ne_q;
  logic [1:0]      cmd_q, cmd_d;
  logic            res_q, res_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            drop_q, drop_d, ill_q, ill_d, tout_q, tout_d;

  logic            legal_op, push_req, push, pop, empty, full, handshake;
  logic [1:0]      push_cmd;
  logic            push_res;
  logic [2:0]      head;

  assign legal_op  = is_op && ((op_in == 3'b001) || (op_in == 3'b010));
  assign push_req  = legal_op || (!is_op && is_enter);
  assign push_cmd  = is_op ? op_in[1:0] : 2'b11;
  assign push_res  = is_op && is_result;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head      = mem_q[rptr_q[AW-1:0]];

  // ne_q lags the FIFO occupancy by one cycle, so a fresh entry reaches the FSM
  // one cycle after it is written; the !empty term keeps the stale flag from popping air.
  assign pop       = (state_q == IDLE) && ne_q && !empty;
  assign push      = push_req && (!full || pop);
  assign handshake = (state_q == ISSUE) && alu.alu_ready;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    res_d   = res_q;
    tmo_d   = tmo_q;
    tout_d  = 1'b0;
    drop_d  = push_req && !push;
    ill_d   = is_op && !legal_op;
    wptr_d  = wptr_q + (AW + 1)'(push);
    rptr_d  = rptr_q + (AW + 1)'(pop);
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          cmd_d   = head[2:1];
          res_d   = head[0];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (alu.alu_ready) begin
          if (res_q) begin
            state_d = WAIT_DONE;
            tmo_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (alu.alu_done) begin
          state_d = IDLE;
        end else if (tmo_q == TW'(DONE_TIMEOUT - 1)) begin
          tout_d  = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      ne_q    <= 1'b0;
      cmd_q   <= '0;
      res_q   <= 1'b0;
      tmo_q   <= '0;
      drop_q  <= 1'b0;
      ill_q   <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      ne_q    <= !empty;
      cmd_q   <= cmd_d;
      res_q   <= res_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
      ill_q   <= ill_d;
      tout_q  <= tout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (nrst && push) begin
      mem_q[wptr_q[AW-1:0]] <= {push_cmd, push_res};
    end
  end

  assign alu.alu_valid  = (state_q == ISSUE);
  assign alu.alu_cmd    = (state_q == ISSUE) ? cmd_q : '0;
  assign alu.alu_result = (state_q == ISSUE) && res_q;
  assign busy           = (state_q != IDLE) || !empty;
  assign drop_pulse     = drop_q;
  assign illegal_pulse  = ill_q;
  assign timeout_pulse  = tout_q;

`ifdef OPCODE_DECODER_STATS_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (handshake && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cmd_count = cnt_q;
`else
  assign cmd_count = '0;
`endif

endmodule

// File: tb/tb_opcode_decoder.sv
// Self-checking bench for opcode_decoder: decode table, directed corner sequences and a randomized model run.
module tb_opcode_decoder;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 15;
`ifdef OPCODE_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic [2:0] op_in = '0;
  logic       is_op = 1'b0, is_result = 1'b0, is_enter = 1'b0;
  logic       busy, drop_pulse, illegal_pulse, timeout_pulse;
  logic [7:0] cmd_count;

  opcode_decoder_if alu();

  opcode_decoder #(.DEPTH(DEPTH), .DONE_TIMEOUT(TMO)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .op_in        (op_in),
    .is_op        (is_op),
    .is_result    (is_result),
    .is_enter     (is_enter),
    .alu          (alu),
    .busy         (busy),
    .drop_pulse   (drop_pulse),
    .illegal_pulse(illegal_pulse),
    .timeout_pulse(timeout_pulse),
    .cmd_count    (cmd_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    is_op = 1'b0; op_in = '0; is_result = 1'b0; is_enter = 1'b0; alu.alu_done = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    alu.alu_ready = 1'b0;
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
  endtask

  // Reference model: a queue whose head becomes issuable two edges after it was written.
  typedef struct { logic [1:0] cmd; logic res; int t; } ent_t;
  ent_t       q[$];
  int         m_phase, m_wait, m_cyc, m_cnt;
  logic [1:0] m_cmd;
  logic       m_res, m_ill, m_drop, m_tout;

  task automatic model_clear;
    q.delete();
    m_phase = 0; m_wait = 0; m_cnt = 0; m_cmd = '0; m_res = 1'b0;
    m_ill = 1'b0; m_drop = 1'b0; m_tout = 1'b0;
  endtask

  task automatic model_edge;
    logic req, pop, acc;
    if (!nrst) begin
      model_clear();
    end else begin
      m_ill  = is_op && !(op_in == 3'd1 || op_in == 3'd2);
      req    = (is_op && !m_ill) || (!is_op && is_enter);
      pop    = (m_phase == 0) && (q.size() > 0) && (m_cyc >= q[0].t + 2);
      acc    = req && ((q.size() < DEPTH) || pop);
      m_drop = req && !acc;
      m_tout = 1'b0;
      case (m_phase)
        0: if (pop) begin m_cmd = q[0].cmd; m_res = q[0].res; m_phase = 1; end
        1: if (alu.alu_ready) begin
             if (STATS && m_cnt < 255) m_cnt++;
             m_phase = m_res ? 2 : 0;
             m_wait  = 0;
           end
        default: if (alu.alu_done) m_phase = 0;
                 else begin
                   m_wait++;
                   if (m_wait == TMO) begin m_tout = 1'b1; m_phase = 0; end
                 end
      endcase
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{cmd: (is_op ? op_in[1:0] : 2'b11), res: (is_op && is_result), t: m_cyc});
    end
    m_cyc++;
  endtask

  task automatic model_compare;
    check("rnd_valid",   alu.alu_valid,  m_phase == 1);
    check("rnd_cmd",     alu.alu_cmd,    (m_phase == 1) ? m_cmd : 2'b00);
    check("rnd_result",  alu.alu_result, (m_phase == 1) && m_res);
    check("rnd_busy",    busy,           (m_phase != 0) || (q.size() > 0));
    check("rnd_drop",    drop_pulse,     m_drop);
    check("rnd_illegal", illegal_pulse,  m_ill);
    check("rnd_timeout", timeout_pulse,  m_tout);
    check("rnd_count",   cmd_count,      m_cnt);
  endtask

  typedef struct {
    logic       op;
    logic [2:0] opc;
    logic       res;
    logic       ent;
    logic       e_ill;
    logic       e_busy;
    logic       e_valid;
    logic [1:0] e_cmd;
    logic       e_res;
  } vec_t;

  vec_t       vt[10];
  logic [1:0] seen[$];
  int         hs, drops;

  initial begin
    alu.alu_ready = 1'b0;
    alu.alu_done  = 1'b0;

    do_reset();
    check("reset_valid", alu.alu_valid, 0);
    check("reset_cmd",   alu.alu_cmd, 0);
    check("reset_busy",  busy, 0);
    check("reset_count", cmd_count, 0);

    //        op   opc     res   ent   ill   busy  valid cmd    res
    vt[0] = '{1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1};
    vt[1] = '{1'b1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0};
    vt[2] = '{1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0};
    vt[3] = '{1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0};
    vt[4] = '{1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0};
    vt[5] = '{1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    vt[6] = '{1'b1, 3'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    vt[7] = '{1'b1, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    vt[8] = '{1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};
    vt[9] = '{1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0};

    for (int i = 0; i < 10; i++) begin
      do_reset();
      is_op = vt[i].op; op_in = vt[i].opc; is_result = vt[i].res; is_enter = vt[i].ent;
      tick();
      idle_inputs();
      check($sformatf("tab%0d_illegal", i), illegal_pulse, vt[i].e_ill);
      check($sformatf("tab%0d_busy", i),    busy,          vt[i].e_busy);
      tick();
      check($sformatf("tab%0d_illegal_once", i), illegal_pulse, 0);
      check($sformatf("tab%0d_valid_e1", i),     alu.alu_valid, 0);
      tick();
      check($sformatf("tab%0d_valid_e2", i), alu.alu_valid,  vt[i].e_valid);
      check($sformatf("tab%0d_cmd", i),      alu.alu_cmd,    vt[i].e_cmd);
      check($sformatf("tab%0d_result", i),   alu.alu_result, vt[i].e_res);
    end

    // ADD with result, handshake immediately, alu_done three cycles later.
    do_reset();
    alu.alu_ready = 1'b1;
    is_op = 1'b1; op_in = 3'd1; is_result = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    check("add_valid", alu.alu_valid, 1);
    check("add_cmd",   alu.alu_cmd, 1);
    check("add_res",   alu.alu_result, 1);
    tick();
    check("add_wait_valid", alu.alu_valid, 0);
    check("add_wait_busy",  busy, 1);
    tick();
    tick();
    check("add_pre_done_busy", busy, 1);
    alu.alu_done = 1'b1;
    tick();
    alu.alu_done = 1'b0;
    check("add_done_busy", busy, 0);
    check("add_no_timeout", timeout_pulse, 0);

    // FIFO overflow: an ADD holds the ISSUE slot, five ENTERs follow, the fifth is lost.
    do_reset();
    is_op = 1'b1; op_in = 3'd1;
    tick();
    idle_inputs();
    for (int k = 0; k < 10 && !alu.alu_valid; k++) tick();
    check("ovf_stall_valid", alu.alu_valid, 1);
    for (int k = 0; k < 5; k++) begin
      is_enter = 1'b1;
      tick();
      check($sformatf("ovf_drop%0d", k), drop_pulse, k == 4);
    end
    idle_inputs();
    tick();
    check("ovf_drop_once", drop_pulse, 0);
    alu.alu_ready = 1'b1;
    seen.delete();
    for (int k = 0; k < 40 && busy; k++) begin
      if (alu.alu_valid) seen.push_back(alu.alu_cmd);
      tick();
    end
    check("ovf_drained", busy, 0);
    check("ovf_issues", seen.size(), 5);
    for (int k = 0; k < seen.size() && k < 5; k++)
      check($sformatf("ovf_order%0d", k), seen[k], (k == 0) ? 2'b01 : 2'b11);

    // SUB expecting a result that never arrives; a queued ENTER must follow the timeout.
    do_reset();
    alu.alu_ready = 1'b1;
    is_op = 1'b1; op_in = 3'd2; is_result = 1'b1;
    tick();
    idle_inputs();
    is_enter = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("tmo_sub_cmd", alu.alu_cmd, 2'b10);
    tick();
    check("tmo_wait_valid", alu.alu_valid, 0);
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("tmo_pulse%0d", k), timeout_pulse, k == 15);
    end
    tick();
    check("tmo_next_valid", alu.alu_valid, 1);
    check("tmo_next_cmd",   alu.alu_cmd, 2'b11);
    check("tmo_pulse_once", timeout_pulse, 0);

    // Reset during ISSUE with two commands queued behind it.
    do_reset();
    is_op = 1'b1; op_in = 3'd1;
    tick();
    idle_inputs();
    is_enter = 1'b1;
    tick();
    tick();
    idle_inputs();
    check("rst_mid_valid_pre", alu.alu_valid, 1);
    nrst = 1'b0;
    tick();
    check("rst_mid_valid", alu.alu_valid, 0);
    check("rst_mid_busy",  busy, 0);
    nrst = 1'b1;
    alu.alu_ready = 1'b1;
    hs = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (alu.alu_valid || busy) hs++;
    end
    check("rst_mid_stale", hs, 0);

    // 300 ENTER handshakes, one strobe every other cycle.
    do_reset();
    alu.alu_ready = 1'b1;
    hs = 0; drops = 0;
    for (int i = 0; i < 600; i++) begin
      is_enter = (i % 2 == 0);
      if (alu.alu_valid) hs++;
      tick();
      if (drop_pulse) drops++;
    end
    idle_inputs();
    for (int k = 0; k < 20; k++) begin
      if (alu.alu_valid) hs++;
      tick();
    end
    check("stats_handshakes", hs, 300);
    check("stats_drops", drops, 0);
    check("stats_count", cmd_count, STATS ? 8'hFF : 8'h00);

    // Randomized run against the reference model, including occasional resets.
    do_reset();
    model_clear();
    for (int i = 0; i < 3000; i++) begin
      nrst          = ($urandom_range(0, 299) != 0);
      is_op         = ($urandom_range(0, 9) < 3);
      is_enter      = ($urandom_range(0, 9) < 3);
      is_result     = $urandom_range(0, 1);
      op_in         = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 2));
      alu.alu_ready = ($urandom_range(0, 9) < (((i / 200) % 2 == 1) ? 2 : 8));
      alu.alu_done  = ($urandom_range(0, 99) < (((i / 300) % 2 == 1) ? 3 : 20));
      model_edge();
      tick();
      model_compare();
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
